alu_cmd_queue: RTL and testbench

Command buffer and issue stage that sits directly upstream of the team's 8-bit ALU.
- Accepts ALU commands (operand A, operand B, op code) over a valid/ready handshake and stores them in a small FIFO.
- Issues one command per cycle to the ALU operand ports, with a one-cycle valid_data strobe, whenever the ALU side is not stalled.
- Lets producers burst commands without tracking ALU timing.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/alu_cmd_queue.sv | 103 ++++++++++
 tb/tb_alu_cmd_queue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU and the blocks that feed it.
//   ALU_WIDTH  : operand width of the ALU datapath
//   ALU_OPCODE : op code width of the ALU
//   alu_op_e   : op code encodings understood by the ALU
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH  = 8;
    localparam int ALU_OPCODE = 3;

    typedef enum logic [ALU_OPCODE-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_SHL1 = 3'b110,
        OP_SHL2 = 3'b111
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a combinational head read.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_data at the tail (ignored when full or flushing)
//   pop        : advance past the head entry (ignored when empty or flushing)
//   flush      : synchronous clear of all entries; wins over push and pop
//   wr_data    : entry to write
//   rd_data    : current head entry (valid while !empty)
//   full/empty : occupancy flags
//   level      : number of stored entries, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable and
// the occupancy is simply wr_ptr - rd_ptr.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; an entry is only ever read after it has been
    // written, and leaving it out keeps the array mappable onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule : sync_fifo

// File: rtl/alu_cmd_queue.sv
// -----------------------------------------------------------------------------
// alu_cmd_queue
// Command buffer and issue stage in front of the 8-bit ALU. Producers push
// {A, B, op} commands over valid/ready; one command per cycle is issued into
// registered ALU operand ports with a one-cycle valid_data strobe.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd_valid    : producer presents a command
//   cmd_ready    : queue can accept (not full)
//   cmd_a/b/op   : command operands and op code
//   alu_stall    : downstream hold; no issue while high
//   flush        : synchronous clear of all queued commands
//   data_in1/2   : registered operands to the ALU (hold when not issuing)
//   op_code      : registered op code to the ALU
//   valid_data   : one-cycle issue strobe
//   level        : number of queued commands
//   overflow_err : sticky; set when cmd_valid is seen while full
// -----------------------------------------------------------------------------
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int OPCODE = ALU_OPCODE,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [OPCODE-1:0]      cmd_op,
    input  logic                   alu_stall,
    input  logic                   flush,
    output logic [WIDTH-1:0]       data_in1,
    output logic [WIDTH-1:0]       data_in2,
    output logic [OPCODE-1:0]      op_code,
    output logic                   valid_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow_err
);

    localparam int EW = 2 * WIDTH + OPCODE;

    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          issue;

    // Entry layout: {op, B, A}.
    assign wr_entry = {cmd_op, cmd_b, cmd_a};

    // A full queue never accepts, even if the head issues on the same edge:
    // cmd_ready is a pure function of the stored occupancy.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full && !flush;
    assign issue     = !fifo_empty && !alu_stall && !flush;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (issue),
        .flush   (flush),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Issue registers: operands only load on an issue so the ALU inputs do not
    // toggle while idle, stalled or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in1   <= '0;
            data_in2   <= '0;
            op_code    <= '0;
            valid_data <= 1'b0;
        end else begin
            valid_data <= issue;
            if (issue) begin
                data_in1 <= head_entry[WIDTH-1:0];
                data_in2 <= head_entry[2*WIDTH-1:WIDTH];
                op_code  <= head_entry[EW-1:2*WIDTH];
            end
        end
    end

    // Sticky overflow: only reset clears it; flush deliberately leaves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (cmd_valid && fifo_full) begin
            overflow_err <= 1'b1;
        end
    end

endmodule : alu_cmd_queue

// File: tb/tb_alu_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_queue
// Directed bench for alu_cmd_queue (WIDTH=8, OPCODE=3, DEPTH=4). Inputs change
// and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_queue;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic       alu_stall;
    logic       flush;
    logic [7:0] data_in1;
    logic [7:0] data_in2;
    logic [2:0] op_code;
    logic       valid_data;
    logic [2:0] level;
    logic       overflow_err;

    int total = 0;
    int bad   = 0;

    alu_cmd_queue #(
        .WIDTH  (8),
        .OPCODE (3),
        .DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_stall    (alu_stall),
        .flush        (flush),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .op_code      (op_code),
        .valid_data   (valid_data),
        .level        (level),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {valid, A, B, op}
    function automatic logic [19:0] issue_vec();
        return {valid_data, data_in1, data_in2, op_code};
    endfunction

    task automatic test_reset();
        logic [23:0] obs;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        alu_stall = 1'b0;
        flush     = 1'b0;
        #1;
        obs = {issue_vec(), level, cmd_ready};
        total++;
        if (obs !== {1'b0, 8'h00, 8'h00, 3'b000, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs, {1'b0, 8'h00, 8'h00, 3'b000, 3'd0, 1'b1});
        end
        total++;
        if (overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_overflow: got %b want 0", overflow_err);
        end
        #12 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({valid_data, level, cmd_ready} !== {1'b0, 3'd0, 1'b1}) begin
                bad++;
                $display("FAIL idle_cycle%0d: valid=%b level=%0d ready=%b want 0/0/1", i, valid_data, level, cmd_ready);
            end
        end
    endtask

    task automatic test_single();
        cmd_valid = 1'b1;
        cmd_a     = 8'h05;
        cmd_b     = 8'h03;
        cmd_op    = 3'b000;
        step();                       // edge 1: push
        cmd_valid = 1'b0;
        total++;
        if ({valid_data, level} !== {1'b0, 3'd1}) begin
            bad++;
            $display("FAIL single_queued: valid=%b level=%0d want 0/1", valid_data, level);
        end
        step();                       // edge 2: issue
        total++;
        if (issue_vec() !== {1'b1, 8'h05, 8'h03, 3'b000}) begin
            bad++;
            $display("FAIL single_issue: got %h want %h", issue_vec(), {1'b1, 8'h05, 8'h03, 3'b000});
        end
        step();
        total++;
        if ({issue_vec(), level} !== {1'b0, 8'h05, 8'h03, 3'b000, 3'd0}) begin
            bad++;
            $display("FAIL single_hold: got %h want %h", {issue_vec(), level}, {1'b0, 8'h05, 8'h03, 3'b000, 3'd0});
        end
    endtask

    task automatic test_stall_full();
        logic [2:0] ops [4];
        ops[0] = 3'b010;
        ops[1] = 3'b011;
        ops[2] = 3'b100;
        ops[3] = 3'b101;
        alu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'(8'h10 + i);
            cmd_b     = 8'(8'h20 + i);
            cmd_op    = ops[i];
            step();
            total++;
            if ({valid_data, level} !== {1'b0, 3'(i + 1)}) begin
                bad++;
                $display("FAIL stall_fill%0d: valid=%b level=%0d want 0/%0d", i, valid_data, level, i + 1);
            end
        end
        total++;
        if ({cmd_ready, overflow_err} !== 2'b00) begin
            bad++;
            $display("FAIL full_flags: ready=%b ovf=%b want 0/0", cmd_ready, overflow_err);
        end
        cmd_a  = 8'hEE;
        cmd_op = 3'b110;              // fifth command, queue full
        step();
        cmd_valid = 1'b0;
        total++;
        if ({overflow_err, level, valid_data} !== {1'b1, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL overflow: ovf=%b level=%0d valid=%b want 1/4/0", overflow_err, level, valid_data);
        end
        alu_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({issue_vec(), level} !== {1'b1, 8'(8'h10 + i), 8'(8'h20 + i), ops[i], 3'(3 - i)}) begin
                bad++;
                $display("FAIL drain%0d: got %h want %h", i, {issue_vec(), level},
                         {1'b1, 8'(8'h10 + i), 8'(8'h20 + i), ops[i], 3'(3 - i)});
            end
        end
        step();
        total++;
        if ({valid_data, level, op_code} !== {1'b0, 3'd0, 3'b101}) begin
            bad++;
            $display("FAIL drain_end: valid=%b level=%0d op=%b want 0/0/101", valid_data, level, op_code);
        end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_a     = 8'd0;
        cmd_b     = 8'hA0;
        cmd_op    = 3'd0;
        step();
        for (int i = 1; i <= 16; i++) begin
            cmd_a  = 8'(i);
            cmd_b  = 8'(8'hA0 + i);
            cmd_op = 3'(i);
            step();
            total++;
            if ({issue_vec(), level} !== {1'b1, 8'(i - 1), 8'(8'hA0 + i - 1), 3'(i - 1), 3'd1}) begin
                bad++;
                $display("FAIL stream%0d: got %h want %h", i, {issue_vec(), level},
                         {1'b1, 8'(i - 1), 8'(8'hA0 + i - 1), 3'(i - 1), 3'd1});
            end
        end
        cmd_valid = 1'b0;
        step();
        total++;
        if ({issue_vec(), level} !== {1'b1, 8'd16, 8'hB0, 3'd0, 3'd0}) begin
            bad++;
            $display("FAIL stream_last: got %h want %h", {issue_vec(), level}, {1'b1, 8'd16, 8'hB0, 3'd0, 3'd0});
        end
        step();
        total++;
        if ({valid_data, level} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL stream_idle: valid=%b level=%0d want 0/0", valid_data, level);
        end
    endtask

    task automatic test_flush();
        alu_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'(8'h20 + i);
            cmd_b     = 8'(8'h30 + i);
            cmd_op    = 3'(i);
            step();
        end
        cmd_valid = 1'b0;
        alu_stall = 1'b0;
        step();                       // first issue
        total++;
        if ({issue_vec(), level} !== {1'b1, 8'h21, 8'h31, 3'd1, 3'd2}) begin
            bad++;
            $display("FAIL flush_first_issue: got %h want %h", {issue_vec(), level}, {1'b1, 8'h21, 8'h31, 3'd1, 3'd2});
        end
        flush     = 1'b1;             // flush during the first issue cycle, with a push
        cmd_valid = 1'b1;
        cmd_a     = 8'h77;
        cmd_b     = 8'h88;
        cmd_op    = 3'd7;
        step();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        total++;
        if ({issue_vec(), level} !== {1'b0, 8'h21, 8'h31, 3'd1, 3'd0}) begin
            bad++;
            $display("FAIL flush_edge: got %h want %h", {issue_vec(), level}, {1'b0, 8'h21, 8'h31, 3'd1, 3'd0});
        end
        total++;
        if (overflow_err !== 1'b1) begin
            bad++;
            $display("FAIL flush_keeps_ovf: got %b want 1", overflow_err);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({valid_data, level, data_in1} !== {1'b0, 3'd0, 8'h21}) begin
                bad++;
                $display("FAIL post_flush%0d: valid=%b level=%0d a=%h want 0/0/21", i, valid_data, level, data_in1);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] obs;
        alu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'(8'h50 + i);
            cmd_b     = 8'(8'h60 + i);
            cmd_op    = 3'(i + 2);
            step();
        end
        cmd_valid = 1'b0;
        total++;
        if (level !== 3'd3) begin
            bad++;
            $display("FAIL pre_reset_level: got %0d want 3", level);
        end
        #2 rst_n = 1'b0;              // mid-cycle, no clock edge
        #1;
        obs = {issue_vec(), level, cmd_ready};
        total++;
        if ({obs, overflow_err} !== {1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", {obs, overflow_err},
                     {1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0});
        end
        #2 rst_n = 1'b1;
        alu_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({valid_data, level} !== {1'b0, 3'd0}) begin
                bad++;
                $display("FAIL post_reset%0d: valid=%b level=%0d want 0/0", i, valid_data, level);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_cmd_queue
